// File: rtl/iddmm_pkg.sv
// iddmm_pkg: shared defaults, FSM state encoding and operand write-enable bit positions.
package iddmm_pkg;
  localparam int K_DEF = 128;
  localparam int N_DEF = 32;
  localparam int ADDR_W_DEF = $clog2(N_DEF);
  localparam int WR_X = 0;
  localparam int WR_Y = 1;
  localparam int WR_M = 2;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RELEASE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot pick of the first requester at or after ptr, searching upward with wrap.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick
);
  logic [PW-1:0] j;
  always_comb begin
    pick = '0;
    j = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % NREQ);
      if (req[j]) begin
        pick = '0;
        pick[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/iddmm_core_arbiter.sv
// iddmm_core_arbiter: round-robin session arbiter sharing one IDDMM core among NREQ clients.
// Optional LOAD watchdog enabled by defining IDDMM_ARB_TIMEOUT_EN.
module iddmm_core_arbiter
  import iddmm_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int K = K_DEF,
  parameter int N = N_DEF,
  parameter int LOAD_TIMEOUT = 256,
  localparam int ADDR_W = $clog2(N),
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  input  logic [3*NREQ-1:0]        cli_wr_ena,
  input  logic [NREQ*ADDR_W-1:0]   cli_wr_addr,
  input  logic [NREQ*K-1:0]        cli_wr_x,
  input  logic [NREQ*K-1:0]        cli_wr_y,
  input  logic [NREQ*K-1:0]        cli_wr_m,
  input  logic [NREQ-1:0]          cli_task_req,
  output logic [NREQ-1:0]          cli_task_end,
  output logic [NREQ-1:0]          cli_task_grant,
  output logic [K-1:0]             cli_task_res,
  output logic [2:0]               core_wr_ena,
  output logic [ADDR_W-1:0]        core_wr_addr,
  output logic [K-1:0]             core_wr_x,
  output logic [K-1:0]             core_wr_y,
  output logic [K-1:0]             core_wr_m,
  output logic                     core_task_req,
  input  logic                     core_task_end,
  input  logic                     core_task_grant,
  input  logic [K-1:0]             core_task_res,
  output logic                     busy,
  output logic                     err_timeout
);
  state_t state, nxt;
  logic [PW-1:0] rr_ptr, owner, pick_idx, ptr_inc;
  logic [NREQ-1:0] pick;
  logic [2:0] own_ena;
  logic [ADDR_W:0] res_cnt;
  logic tmo, act;
  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(req), .ptr(rr_ptr), .pick(pick));
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end
  assign ptr_inc = owner == PW'(NREQ - 1) ? '0 : owner + 1'b1;
  assign own_ena = cli_wr_ena[int'(owner)*3 +: 3];
`ifdef IDDMM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(LOAD_TIMEOUT + 1);
  logic [TW-1:0] load_cnt;
  assign tmo = state == LOAD && load_cnt == TW'(LOAD_TIMEOUT - 1) && req[owner] && !cli_task_req[owner];
  always_ff @(posedge clk or posedge rst)
    if (rst) load_cnt <= '0;
    else load_cnt <= state == LOAD ? load_cnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  assign err_timeout = tmo;
  always_comb
    nxt = state == IDLE ? (|req ? LOAD : IDLE)
        : state == LOAD ? (!req[owner] ? IDLE : cli_task_req[owner] ? RUN : tmo ? RELEASE : LOAD)
        : state == RUN  ? (core_task_end ? RELEASE : RUN)
        : IDLE;
  // Forward owner traffic only while the session stays in LOAD/RUN, so IDLE/RELEASE see no writes.
  assign act = (state == LOAD || state == RUN) && (nxt == LOAD || nxt == RUN);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      gnt <= '0;
      core_wr_ena <= '0;
      core_wr_addr <= '0;
      core_wr_x <= '0;
      core_wr_y <= '0;
      core_wr_m <= '0;
      core_task_req <= 1'b0;
      res_cnt <= '0;
    end else begin
      state <= nxt;
      core_wr_ena[WR_X] <= act & own_ena[WR_X];
      core_wr_ena[WR_Y] <= act & own_ena[WR_Y];
      core_wr_ena[WR_M] <= act & own_ena[WR_M];
      core_task_req <= act & cli_task_req[owner];
      if (act) begin
        core_wr_addr <= cli_wr_addr[int'(owner)*ADDR_W +: ADDR_W];
        core_wr_x <= cli_wr_x[int'(owner)*K +: K];
        core_wr_y <= cli_wr_y[int'(owner)*K +: K];
        core_wr_m <= cli_wr_m[int'(owner)*K +: K];
      end
      if (state == IDLE && nxt == LOAD) begin
        owner <= pick_idx;
        gnt <= pick;
        res_cnt <= '0;
      end
      if (nxt == IDLE || nxt == RELEASE) gnt <= '0;
      if (nxt == RELEASE) rr_ptr <= ptr_inc;
      if (state == RUN && core_task_grant) res_cnt <= res_cnt + 1'b1;
    end
  assign cli_task_end = (state == RUN && core_task_end) ? gnt : '0;
  assign cli_task_grant = (state == RUN && core_task_grant) ? gnt : '0;
  assign cli_task_res = core_task_res;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_iddmm_core_arbiter.sv
// tb_iddmm_core_arbiter: directed sessions checked each cycle against a session-level model.
module tb_iddmm_core_arbiter;
  localparam int NREQ = 2;
  localparam int K = iddmm_pkg::K_DEF;
  localparam int N = iddmm_pkg::N_DEF;
  localparam int AW = iddmm_pkg::ADDR_W_DEF;
  localparam int LT = 8;
`ifdef IDDMM_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam int NW = TMO ? 6 : N;
  logic clk = 0, rst = 0;
  logic [NREQ-1:0] req = '0, cli_task_req = '0, gnt, cli_task_end, cli_task_grant;
  logic [3*NREQ-1:0] cli_wr_ena = '0;
  logic [NREQ*AW-1:0] cli_wr_addr = '0;
  logic [NREQ*K-1:0] cli_wr_x = '0, cli_wr_y = '0, cli_wr_m = '0;
  logic [K-1:0] cli_task_res, core_wr_x, core_wr_y, core_wr_m, core_task_res = '0;
  logic [2:0] core_wr_ena;
  logic [AW-1:0] core_wr_addr;
  logic core_task_req, core_task_end = 0, core_task_grant = 0, busy, err_timeout;
  int checks = 0, errors = 0;
  iddmm_core_arbiter #(.NREQ(NREQ), .K(K), .N(N), .LOAD_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .cli_wr_ena(cli_wr_ena), .cli_wr_addr(cli_wr_addr),
    .cli_wr_x(cli_wr_x), .cli_wr_y(cli_wr_y), .cli_wr_m(cli_wr_m),
    .cli_task_req(cli_task_req), .cli_task_end(cli_task_end),
    .cli_task_grant(cli_task_grant), .cli_task_res(cli_task_res),
    .core_wr_ena(core_wr_ena), .core_wr_addr(core_wr_addr),
    .core_wr_x(core_wr_x), .core_wr_y(core_wr_y), .core_wr_m(core_wr_m),
    .core_task_req(core_task_req), .core_task_end(core_task_end),
    .core_task_grant(core_task_grant), .core_task_res(core_task_res),
    .busy(busy), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Session model: phase 0 idle, 1 loading, 2 running, 3 releasing.
  int ph = 0, own = 0, ptr = 0, age = 0;
  logic [2:0] x_ena = '0;
  logic x_treq = 0;
  logic [AW-1:0] x_addr = '0;
  logic [K-1:0] x_x = '0, x_y = '0, x_m = '0;
  always @(posedge clk or posedge rst) begin
    bit live;
    live = 0;
    if (rst) begin
      ph = 0; own = 0; ptr = 0; age = 0; x_ena = '0; x_treq = 0;
    end else begin
      if (ph == 0) begin
        if (req != 0) begin
          for (int i = NREQ - 1; i >= 0; i--)
            if (req[(ptr + i) % NREQ]) own = (ptr + i) % NREQ;
          ph = 1;
          age = 0;
        end
      end else if (ph == 1) begin
        if (!req[own]) ph = 0;
        else if (cli_task_req[own]) begin ph = 2; live = 1; end
        else if (TMO && age == LT - 1) begin ph = 3; ptr = (own + 1) % NREQ; end
        else begin live = 1; age++; end
      end else if (ph == 2) begin
        if (core_task_end) begin ph = 3; ptr = (own + 1) % NREQ; end
        else live = 1;
      end else ph = 0;
      x_ena = live ? cli_wr_ena[own*3 +: 3] : 3'b0;
      x_treq = live ? cli_task_req[own] : 1'b0;
      if (live) begin
        x_addr = cli_wr_addr[own*AW +: AW];
        x_x = cli_wr_x[own*K +: K];
        x_y = cli_wr_y[own*K +: K];
        x_m = cli_wr_m[own*K +: K];
      end
    end
  end
  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    eg = (ph == 1 || ph == 2) ? NREQ'(1) << own : '0;
    chk("gnt", gnt, eg);
    chk("busy", busy, ph != 0);
    chk("core_wr_ena", core_wr_ena, x_ena);
    chk("core_task_req", core_task_req, x_treq);
    if (x_ena != 0) begin
      chk("core_wr_addr", core_wr_addr, x_addr);
      chk("core_wr_x", core_wr_x, x_x);
      chk("core_wr_y", core_wr_y, x_y);
      chk("core_wr_m", core_wr_m, x_m);
    end
    chk("cli_task_end", cli_task_end, (ph == 2 && core_task_end) ? eg : '0);
    chk("cli_task_grant", cli_task_grant, (ph == 2 && core_task_grant) ? eg : '0);
    chk("cli_task_res", cli_task_res, core_task_res);
    chk("err_timeout", err_timeout, TMO && ph == 1 && age == LT - 1 && req[own] && !cli_task_req[own]);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int c, input logic [2:0] e, input int a, input logic t);
    cli_wr_ena[c*3 +: 3] = e;
    cli_wr_addr[c*AW +: AW] = AW'(a);
    cli_wr_x[c*K +: K] = K'(c * 256 + a + 1);
    cli_wr_y[c*K +: K] = K'(c * 256 + a + 1) << 64;
    cli_wr_m[c*K +: K] = ~K'(c * 256 + a);
    cli_task_req[c] = t;
  endtask
  // Entered in LOAD for client c; leaves the arbiter back in IDLE.
  task automatic serve(input int c, input int nw, input int ng);
    for (int w = 0; w < nw; w++) begin
      drive(c, 3'b111, w, 1'b0);
      tick;
      if (w == 0) chk("first_write_lit", {core_wr_ena, 3'(core_wr_addr)}, {3'b111, 3'b000});
    end
    drive(c, 3'b000, 0, 1'b1);
    tick;
    chk("start_lit", core_task_req, 1'b1);
    drive(c, 3'b000, 0, 1'b0);
    for (int g = 0; g < ng; g++) begin
      core_task_grant = 1;
      core_task_res = K'(g * 3 + 7);
      #1;
      if (g == 0) chk("grant_route_lit", cli_task_grant, NREQ'(1) << c);
      tick;
    end
    core_task_grant = 0;
    core_task_end = 1;
    #1;
    chk("end_route_lit", cli_task_end, NREQ'(1) << c);
    tick;
    core_task_end = 0;
    chk("release_gnt_lit", {gnt, busy}, {2'b00, 1'b1});
    tick;
  endtask
  initial begin
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_lit", {gnt, core_wr_ena, core_task_req, busy, err_timeout}, 8'h00);
    // Single client session with a full operand load
    req = 2'b01;
    tick;
    chk("first_grant_lit", gnt, 2'b01);
    serve(0, NW, N);
    req = 2'b00;
    core_task_end = 1;
    core_task_grant = 1;
    #1;
    chk("stray_end_lit", {cli_task_end, cli_task_grant}, 4'b0000);
    tick;
    core_task_end = 0;
    core_task_grant = 0;
    tick;
    // Both clients from reset; client1 writes are ignored while client0 owns
    rst = 1;
    tick;
    rst = 0;
    req = 2'b11;
    tick;
    chk("rr_first_c0_lit", gnt, 2'b01);
    drive(1, 3'b111, 9, 1'b0);
    serve(0, 4, 3);
    drive(1, 3'b000, 0, 1'b0);
    tick;
    chk("rr_then_c1_lit", gnt, 2'b10);
    serve(1, 2, 2);
    tick;
    chk("rr_back_c0_lit", gnt, 2'b01);
    // Owner drops in LOAD, then drops in RUN
    req = 2'b10;
    tick;
    chk("drop_load_idle_lit", {gnt, busy}, 3'b000);
    req = 2'b11;
    tick;
    chk("drop_ptr_kept_lit", gnt, 2'b01);
    drive(0, 3'b000, 0, 1'b1);
    tick;
    drive(0, 3'b000, 0, 1'b0);
    req = 2'b10;
    repeat (3) tick;
    chk("drop_run_held_lit", gnt, 2'b01);
    core_task_end = 1;
    tick;
    core_task_end = 0;
    tick;
    tick;
    chk("after_drop_c1_lit", gnt, 2'b10);
    // Asynchronous reset while the core is running
    drive(1, 3'b000, 0, 1'b1);
    tick;
    #2 rst = 1;
    #1;
    chk("rst_mid_run_lit", {gnt, core_task_req, busy}, 4'b0000);
    drive(1, 3'b000, 0, 1'b0);
    tick;
    rst = 0;
    tick;
    chk("post_rst_load_lit", gnt, 2'b10);
    req = 2'b00;
    tick;
    tick;
`ifdef IDDMM_ARB_TIMEOUT_EN
    req = 2'b11;
    tick;
    repeat (LT - 1) tick;
    chk("timeout_pulse_lit", err_timeout, 1'b1);
    tick;
    chk("timeout_release_lit", {err_timeout, gnt}, 3'b000);
    tick;
    tick;
    chk("timeout_next_lit", gnt, 2'b10);
    req = 2'b00;
    tick;
    tick;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
